enemy_ctrl: RTL and testbench

- Downstream neighbour of the player/bullet/wall renderer.
- Consumes the bullet position registers and the shared pixel coordinates, and animates a single enemy sprite. The enemy marches horizontally, reverses and drops at the side walls, and explodes when hit.
- Maintains score and game-over status.
- Outputs its own rgb and enemy_on; the top-level mux ORs it with the wall layer.

---
 rtl/enemy_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_enemy_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_ctrl.sv
// enemy_ctrl -- single enemy sprite layer for the shooter game.
//
// The enemy marches horizontally one step per frame, reverses and drops at
// the side walls, explodes (blinking) when struck by an in-flight bullet and
// ends the game when its bottom edge reaches the player row. Score and the
// sticky game-over flag are maintained here as well.
//
// Optional feature macro: ENEMY_SPEEDUP_EN
//   When defined, the horizontal step grows by one pixel for every four hits
//   (capped at +3) and the larger step also moves the wall-reversal points.
//
// Ports:
//   clk        in   1   pixel-rate clock
//   reset      in   1   synchronous, active-low reset
//   video_on   in   1   visible-area flag
//   pix_x      in  11   current pixel x
//   pix_y      in  11   current pixel y
//   bull_x     in  11   bullet x register from the player block
//   bull_y     in  11   bullet bottom-y register from the player block
//   rgb        out  3   enemy layer colour (000 outside the sprite)
//   enemy_on   out  1   pixel inside enemy box and layer colour non-black
//   hit        out  1   one-clock pulse on a scored hit
//   score      out  8   saturating hit count
//   game_over  out  1   sticky end-of-game flag
module enemy_ctrl #(
  parameter int ENEMY_W     = 16,
  parameter int ENEMY_H     = 12,
  parameter int ENEMY_X0    = 100,
  parameter int ENEMY_Y0    = 20,
  parameter int ENEMY_VX    = 1,
  parameter int ENEMY_DROP  = 8,
  parameter int LAND_Y      = 465,
  parameter int EXPL_FRAMES = 16,
  parameter int BULL_IDLE_Y = 464
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic [10:0] bull_x,
  input  logic [10:0] bull_y,
  output logic [2:0]  rgb,
  output logic        enemy_on,
  output logic        hit,
  output logic [7:0]  score,
  output logic        game_over
);

  localparam logic [10:0] W_M1      = 11'(ENEMY_W - 1);
  localparam logic [10:0] H_M1      = 11'(ENEMY_H - 1);
  localparam logic [10:0] X0        = 11'(ENEMY_X0);
  localparam logic [10:0] Y0        = 11'(ENEMY_Y0);
  localparam logic [10:0] VX        = 11'(ENEMY_VX);
  localparam logic [10:0] DROP      = 11'(ENEMY_DROP);
  localparam logic [10:0] LAND      = 11'(LAND_Y);
  localparam logic [10:0] IDLE_Y    = 11'(BULL_IDLE_Y);
  localparam logic [7:0]  EXPL_LAST = 8'(EXPL_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'b00,
    ST_EXPLODE   = 2'b01,
    ST_GAME_OVER = 2'b10
  } state_t;

  state_t      state_r, state_s;
  logic [10:0] ex_r, ex_s;
  logic [10:0] ey_r, ey_s;
  logic        dir_r, dir_s;        // 0 = moving right, 1 = moving left
  logic [7:0]  expl_cnt_r, expl_cnt_s;
  logic [7:0]  score_r, score_s;
  logic        hit_r, hit_s;
  logic        game_over_r, game_over_s;

  logic        frame_tick_s;
  logic [10:0] step_s;
  logic [10:0] ex_right_s, ey_bot_s, ey_drop_s;
  logic [10:0] bx_l_s, bx_r_s, by_t_s;
  logic        in_flight_s, overlap_s;
  logic        in_box_s;
  logic [2:0]  colour_s;

  assign frame_tick_s = (pix_y == 11'd481) && (pix_x == 11'd0);

`ifdef ENEMY_SPEEDUP_EN
  logic [1:0] boost_s;

  // Speed bonus: one extra pixel per four hits, capped at three.
  always_comb begin
    if (score_r[7:2] > 6'd3) begin
      boost_s = 2'd3;
    end else begin
      boost_s = score_r[3:2];
    end
  end

  assign step_s = VX + {9'd0, boost_s};
`else
  assign step_s = VX;
`endif

  assign ex_right_s  = ex_r + W_M1;
  assign ey_bot_s    = ey_r + H_M1;
  assign ey_drop_s   = ey_r + DROP;

  // Bullet hit box is a 4-px wide column offset 3 px into the bullet sprite.
  assign bx_l_s      = bull_x + 11'd3;
  assign bx_r_s      = bx_l_s + 11'd3;
  assign by_t_s      = bull_y - 11'd5;
  assign in_flight_s = (bull_y < IDLE_Y);
  assign overlap_s   = (bx_l_s <= ex_right_s) && (bx_r_s >= ex_r) &&
                       (by_t_s <= ey_bot_s)   && (bull_y >= ey_r);

  // Next-state logic: every update is gated by frame_tick; hit self-clears.
  always_comb begin
    state_s     = state_r;
    ex_s        = ex_r;
    ey_s        = ey_r;
    dir_s       = dir_r;
    expl_cnt_s  = expl_cnt_r;
    score_s     = score_r;
    hit_s       = 1'b0;
    game_over_s = game_over_r;
    if (frame_tick_s) begin
      case (state_r)
        ST_ALIVE: begin
          if (in_flight_s && overlap_s) begin
            // A hit takes priority over any move or wall reversal.
            state_s    = ST_EXPLODE;
            expl_cnt_s = 8'd0;
            hit_s      = 1'b1;
            if (score_r != 8'hFF) begin
              score_s = score_r + 8'd1;
            end else begin
              score_s = score_r;
            end
          end else begin
            if (!dir_r && ((ex_right_s + step_s) >= 11'd637)) begin
              dir_s = 1'b1;
              ey_s  = ey_drop_s;
            end else if (dir_r && (ex_r < (11'd3 + step_s))) begin
              dir_s = 1'b0;
              ey_s  = ey_drop_s;
            end else if (dir_r) begin
              ex_s = ex_r - step_s;
            end else begin
              ex_s = ex_r + step_s;
            end
            // Landing check uses the post-move position.
            if ((ey_s + H_M1) >= LAND) begin
              state_s     = ST_GAME_OVER;
              game_over_s = 1'b1;
            end else begin
              game_over_s = game_over_r;
            end
          end
        end
        ST_EXPLODE: begin
          if (expl_cnt_r == EXPL_LAST) begin
            state_s    = ST_ALIVE;
            ex_s       = X0;
            ey_s       = Y0;
            dir_s      = 1'b0;
          end else begin
            expl_cnt_s = expl_cnt_r + 8'd1;
          end
        end
        ST_GAME_OVER: begin
          game_over_s = 1'b1;
        end
        default: begin
          // Unreachable encoding: recover to a clean spawn.
          state_s    = ST_ALIVE;
          ex_s       = X0;
          ey_s       = Y0;
          dir_s      = 1'b0;
          expl_cnt_s = 8'd0;
        end
      endcase
    end else begin
      hit_s = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_ALIVE;
      ex_r        <= X0;
      ey_r        <= Y0;
      dir_r       <= 1'b0;
      expl_cnt_r  <= 8'd0;
      score_r     <= 8'd0;
      hit_r       <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ex_r        <= ex_s;
      ey_r        <= ey_s;
      dir_r       <= dir_s;
      expl_cnt_r  <= expl_cnt_s;
      score_r     <= score_s;
      hit_r       <= hit_s;
      game_over_r <= game_over_s;
    end
  end

  // Sprite colour by state; the explosion blinks black every fourth frame.
  always_comb begin
    case (state_r)
      ST_ALIVE:     colour_s = 3'b010;
      ST_EXPLODE: begin
        if (expl_cnt_r[2]) begin
          colour_s = 3'b000;
        end else begin
          colour_s = 3'b101;
        end
      end
      ST_GAME_OVER: colour_s = 3'b001;
      default:      colour_s = 3'b000;
    endcase
  end

  assign in_box_s  = (pix_x >= ex_r) && (pix_x <= ex_right_s) &&
                     (pix_y >= ey_r) && (pix_y <= ey_bot_s);
  assign enemy_on  = in_box_s && (colour_s != 3'b000);
  assign rgb       = (video_on && enemy_on) ? colour_s : 3'b000;
  assign hit       = hit_r;
  assign score     = score_r;
  assign game_over = game_over_r;

endmodule

// File: tb/tb_enemy_ctrl.sv
// Self-checking bench for enemy_ctrl. Two instances share stimulus: the
// default build and one with ENEMY_DROP=150 so the landing path is reachable
// quickly. A behavioural model predicts pixel and register outputs; expected
// values are queued when stimulus is applied and compared once the DUT has
// responded.
module tb_enemy_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_on;
  logic [10:0] pix_x, pix_y, bull_x, bull_y;
  logic [2:0]  rgb_a, rgb_b;
  logic        on_a, on_b, hit_a, hit_b, go_a, go_b;
  logic [7:0]  score_a, score_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  enemy_ctrl u_dut (
    .clk(clk), .reset(reset), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .bull_x(bull_x), .bull_y(bull_y),
    .rgb(rgb_a), .enemy_on(on_a), .hit(hit_a), .score(score_a),
    .game_over(go_a)
  );

  enemy_ctrl #(.ENEMY_DROP(150)) u_dut_go (
    .clk(clk), .reset(reset), .video_on(video_on),
    .pix_x(pix_x), .pix_y(pix_y), .bull_x(bull_x), .bull_y(bull_y),
    .rgb(rgb_b), .enemy_on(on_b), .hit(hit_b), .score(score_b),
    .game_over(go_b)
  );

  // ---------------- reference model ----------------
  int m_ex[2], m_ey[2], m_dir[2], m_st[2], m_cnt[2], m_score[2], m_hit[2];
  int m_drop[2] = '{8, 150};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ex[i] = 100; m_ey[i] = 20; m_dir[i] = 0; m_st[i] = 0;
      m_cnt[i] = 0; m_score[i] = 0; m_hit[i] = 0;
    end
  endtask

  task automatic model_tick();
    int bl, br, bt, by, bx, stp;
    bx = int'(bull_x); by = int'(bull_y);
    bl = (bx + 3) & 2047;
    br = (bl + 3) & 2047;
    bt = (by - 5) & 2047;
    for (int i = 0; i < 2; i++) begin
      m_hit[i] = 0;
      stp = 1;
`ifdef ENEMY_SPEEDUP_EN
      stp = 1 + (((m_score[i] >> 2) > 3) ? 3 : (m_score[i] >> 2));
`endif
      if (m_st[i] == 1) begin
        if (m_cnt[i] == 15) begin
          m_st[i] = 0; m_ex[i] = 100; m_ey[i] = 20; m_dir[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end else if (m_st[i] == 0) begin
        if (by < 464 && bl <= m_ex[i] + 15 && br >= m_ex[i] &&
            bt <= m_ey[i] + 11 && by >= m_ey[i]) begin
          m_st[i] = 1; m_cnt[i] = 0; m_hit[i] = 1;
          if (m_score[i] < 255) m_score[i] = m_score[i] + 1;
        end else begin
          if (m_dir[i] == 0 && m_ex[i] + 15 + stp >= 637) begin
            m_dir[i] = 1; m_ey[i] = m_ey[i] + m_drop[i];
          end else if (m_dir[i] == 1 && m_ex[i] < 3 + stp) begin
            m_dir[i] = 0; m_ey[i] = m_ey[i] + m_drop[i];
          end else if (m_dir[i] == 1) begin
            m_ex[i] = m_ex[i] - stp;
          end else begin
            m_ex[i] = m_ex[i] + stp;
          end
          if (m_ey[i] + 11 >= 465) m_st[i] = 2;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_pix(int i);
    int x, y;
    logic inb, on;
    logic [2:0] col;
    x = int'(pix_x); y = int'(pix_y);
    inb = (x >= m_ex[i]) && (x <= m_ex[i] + 15) && (y >= m_ey[i]) && (y <= m_ey[i] + 11);
    if (m_st[i] == 0)      col = 3'b010;
    else if (m_st[i] == 1) col = ((m_cnt[i] & 4) != 0) ? 3'b000 : 3'b101;
    else                   col = 3'b001;
    on = inb && (col != 3'b000);
    return {28'd0, on, (video_on && on) ? col : 3'b000};
  endfunction

  function automatic logic [31:0] model_regs(int i);
    return {22'd0, (m_st[i] == 2), (m_hit[i] != 0), 8'(m_score[i])};
  endfunction

  function automatic logic [31:0] dut_val(int sel);
    case (sel)
      0:       return {28'd0, on_a, rgb_a};
      1:       return {28'd0, on_b, rgb_b};
      2:       return {22'd0, go_a, hit_a, score_a};
      default: return {22'd0, go_b, hit_b, score_b};
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  string       q_tag[$];
  int          q_sel[$];
  logic [31:0] q_exp[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, expv, $time);
    end
  endtask

  task automatic push_exp(input string tag, input int sel, input logic [31:0] expv);
    q_tag.push_back(tag); q_sel.push_back(sel); q_exp.push_back(expv);
  endtask

  task automatic drain();
    string t; int s; logic [31:0] e;
    while (q_sel.size() > 0) begin
      t = q_tag.pop_front(); s = q_sel.pop_front(); e = q_exp.pop_front();
      check_val(t, dut_val(s), e);
    end
  endtask

  task automatic probe(input int x, input int y);
    pix_x = 11'(x); pix_y = 11'(y);
    push_exp("pix_a", 0, model_pix(0));
    push_exp("pix_b", 1, model_pix(1));
    #1;
    drain();
  endtask

  task automatic push_regs(input string tag);
    push_exp(tag, 2, model_regs(0));
    push_exp(tag, 3, model_regs(1));
  endtask

  task automatic tick();
    pix_x = 11'd0; pix_y = 11'd481;
    @(posedge clk);
    model_tick();
    #1;
    pix_x = 11'd0; pix_y = 11'd0;
    push_regs("regs_tick");
    drain();
  endtask

  task automatic idle();
    pix_x = 11'd0; pix_y = 11'd0;
    @(posedge clk);
    m_hit[0] = 0; m_hit[1] = 0;
    #1;
    push_regs("regs_idle");
    drain();
  endtask

  task automatic do_reset(input int cycles);
    pix_x = 11'd0; pix_y = 11'd0;
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b1;
    push_regs("regs_reset");
    drain();
  endtask

  task automatic park();
    bull_x = 11'd300; bull_y = 11'd464;
  endtask

  initial begin
    reset = 1'b1; video_on = 1'b1;
    pix_x = 11'd0; pix_y = 11'd0;
    park();
    model_reset();
    @(posedge clk); #1;

    // 1. Reset state and pixel output
    do_reset(3);
    pix_x = 11'd100; pix_y = 11'd20; #1;
    check_val("rst_pix_in", {28'd0, on_a, rgb_a}, 32'h0000_000A);
    pix_x = 11'd99; #1;
    check_val("rst_pix_left", {28'd0, on_a, rgb_a}, 32'h0000_0000);
    probe(115, 31);
    probe(116, 31);
    probe(115, 32);
    video_on = 1'b0; probe(100, 20); video_on = 1'b1;

    // 2. Scored hit and explosion
    bull_x = 11'd102; bull_y = 11'd30;
    tick();
    check_val("hit_pulse", {31'd0, hit_a}, 32'd1);
    idle();
    check_val("hit_clear", {31'd0, hit_a}, 32'd0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      probe(100, 20);
      if (k == 4) check_val("blink_dark", {28'd0, on_a, rgb_a}, 32'h0000_0000);
    end
    park();
    tick();
    probe(100, 20);
    check_val("respawn_pix", {28'd0, on_a, rgb_a}, 32'h0000_000A);
    check_val("score_kept", {24'd0, score_a}, 32'd1);

    // 3. Parked bullet over the sprite column, then edge-of-box cases
    do_reset(1);
    bull_x = 11'd102; bull_y = 11'd464;
    tick();
    probe(101, 20);
    probe(100, 20);
    check_val("parked_move", {28'd0, on_a, rgb_a}, 32'h0000_0000);
    bull_x = 11'd95; bull_y = 11'd20;   // bullet right edge == enemy left edge
    tick();
    park();
    for (int k = 0; k < 16; k++) tick();
    bull_x = 11'd93; bull_y = 11'd20;   // one pixel short: miss
    tick();
    probe(101, 20);
    park();

    // 6. Reset during explosion
    do_reset(1);
    bull_x = 11'd102; bull_y = 11'd30;
    tick();
    park();
    for (int k = 0; k < 5; k++) tick();
    do_reset(1);
    check_val("midexpl_score", {24'd0, score_a}, 32'd0);
    probe(100, 20);

    // 4/5. Wall reversal and landing
    do_reset(1);
    for (int t = 1; t <= 1760; t++) begin
      tick();
      if (t % 97 == 0) probe(m_ex[0], m_ey[0]);
      if (t == 521) begin
        pix_x = 11'd621; pix_y = 11'd20; #1;
        check_val("wall_ex621", {31'd0, on_a}, 32'd1);
        pix_x = 11'd620; #1;
        check_val("wall_ex620_off", {31'd0, on_a}, 32'd0);
      end
      if (t == 522) begin
        pix_x = 11'd621; pix_y = 11'd28; #1;
        check_val("drop_ey28", {31'd0, on_a}, 32'd1);
        pix_y = 11'd27; #1;
        check_val("drop_ey27_off", {31'd0, on_a}, 32'd0);
      end
      if (t == 523) begin
        pix_x = 11'd620; pix_y = 11'd28; #1;
        check_val("left_ex620", {31'd0, on_a}, 32'd1);
        pix_x = 11'd636; #1;
        check_val("left_ex636_off", {31'd0, on_a}, 32'd0);
      end
      if (t == 1759) check_val("go_not_yet", {31'd0, go_b}, 32'd0);
    end
    check_val("go_set", {31'd0, go_b}, 32'd1);
    pix_x = 11'd621; pix_y = 11'd470; #1;
    check_val("go_rgb", {28'd0, on_b, rgb_b}, 32'h0000_0009);
    probe(621, 470);
    probe(621, 44);
    bull_x = 11'd621; bull_y = 11'd463;
    tick();
    check_val("go_no_hit", {31'd0, hit_b}, 32'd0);
    for (int k = 0; k < 3; k++) tick();
    probe(621, 470);
    park();
    do_reset(1);
    check_val("go_cleared", {31'd0, go_b}, 32'd0);

`ifdef ENEMY_SPEEDUP_EN
    // Speed-up: four hits, then two pixels per tick
    for (int h = 0; h < 4; h++) begin
      bull_x = 11'd102; bull_y = 11'd30;
      tick();
      park();
      for (int k = 0; k < 16; k++) tick();
    end
    tick();
    probe(102, 20);
    check_val("speed_step2", {31'd0, on_a}, 32'd1);
    probe(101, 20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
